// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversions and sync depth default.
// Latency: combinational functions only.
// Backpressure: none, package holds no state.
package fifo_pkg;

    localparam int SYNC_STG_DEF = 2;

    // Gray encode; upper unused bits are zero so any narrower pointer can be zero-extended in.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray decode as an XOR prefix running down from the MSB.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; samples d every cycle, no logic ahead of the first flop.
module fifo_gray_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 11,
    parameter int STAGES = SYNC_STG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    // Shift chain; only one bit of a Gray pointer moves per step, so any sample is a valid code.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/fifo_wfull_gen.sv
// Write-domain status: wrap-extended Gray write pointer, synchronised read pointer, full/afull/level.
// Latency: status registered on the edge that latches the write; read-pointer release after SYNC_STG+1 edges.
// Backpressure: wr_full blocks wr_allow upstream from the cycle after the last free slot is written.
module fifo_wfull_gen
    import fifo_pkg::*;
#(
    parameter int          ABITS     = 10,
    parameter int unsigned AFULL_LVL = (1 << ABITS) - 4,
    parameter int          SYNC_STG  = SYNC_STG_DEF
) (
    input  logic             wrclk,
    input  logic             rst_n,
    input  logic             wr_allow,
    input  logic [ABITS-1:0] wr_bin_ptr,
    input  logic [ABITS:0]   rd_gray_ptr,
    output logic [ABITS:0]   wr_gray_ptr,
    output logic             wr_full,
    output logic             wr_afull,
    output logic [ABITS:0]   wr_level
);

    localparam int PW = ABITS + 1;

    logic          wrap_r;
    logic [PW-1:0] wptr;
    logic [PW-1:0] wptr_next;
    logic [PW-1:0] gnext;
    logic [PW-1:0] rq;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] diff;

    fifo_gray_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STG)
    ) u_rsync (
        .clk   (wrclk),
        .rst_n (rst_n),
        .d     (rd_gray_ptr),
        .q     (rq)
    );

    assign wptr      = {wrap_r, wr_bin_ptr};
    assign wptr_next = wptr + PW'(wr_allow);
    assign gnext     = PW'(bin2gray(32'(wptr_next)));
    assign rbin      = PW'(gray2bin(32'(rq)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign full_cmp  = {~rq[ABITS:ABITS-1], rq[ABITS-2:0]};
    // Read side is seen late through the synchroniser, so this count only ever over-reports.
    assign diff      = wptr_next - rbin;

    // Status registers computed from the post-write pointer so full asserts on the filling edge.
    always_ff @(posedge wrclk) begin
        if (!rst_n) begin
            wrap_r      <= 1'b0;
            wr_gray_ptr <= '0;
            wr_full     <= 1'b0;
            wr_afull    <= 1'b0;
            wr_level    <= '0;
        end else begin
            wrap_r      <= wptr_next[ABITS];
            wr_gray_ptr <= gnext;
            wr_full     <= (gnext == full_cmp);
            wr_afull    <= (32'(diff) >= AFULL_LVL);
            wr_level    <= diff;
        end
    end

endmodule
